// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX-stage DIV/DIVU start/ready handshake.
// Optional feature macro: DIV_EARLY_OUT_EN (skip iteration when |dividend| < |divisor|).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd, dvs, rem, quo;
    logic             neg_q, neg_r;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted, trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next, quo_next, q_fix, r_fix;

    assign mag_a = (signed_div_i && opdata1_i[WIDTH-1]) ? ~opdata1_i + ONE : opdata1_i;
    assign mag_b = (signed_div_i && opdata2_i[WIDTH-1]) ? ~opdata2_i + ONE : opdata2_i;

    // Partial remainder is WIDTH+1 bits only transiently; the kept value is always < divisor.
    assign shifted  = {rem, dvd[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], q_bit};
    assign q_fix    = neg_q ? ~quo_next + ONE : quo_next;
    assign r_fix    = neg_r ? ~rem_next + ONE : rem_next;

    assign busy_o = (state == RUN) || (state == ZERO);

`ifdef DIV_EARLY_OUT_EN
    logic early;
    assign early = mag_a < mag_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= ZERO;
                        end
`ifdef DIV_EARLY_OUT_EN
                        else if (early) begin
                            state    <= DONE;
                            result_o <= {opdata1_i, {WIDTH{1'b0}}};
                            ready_o  <= 1'b1;
                        end
`endif
                        else begin
                            state <= RUN;
                            dvd   <= mag_a;
                            dvs   <= mag_b;
                            rem   <= '0;
                            quo   <= '0;
                            cnt   <= '0;
                            neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_r <= signed_div_i & opdata1_i[WIDTH-1];
                        end
                    end
                end
                ZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state    <= DONE;
                end
                RUN: begin
                    if (annul_i || !start_i) begin
                        state    <= IDLE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        dvd <= dvd << 1;
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            result_o <= {r_fix, q_fix};
                            ready_o  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!start_i || annul_i) begin
                        state    <= IDLE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
